shift_add_multiplier_radix: RTL and testbench

Parametrised successor to the single-bit shift-add multiplier: a sequential multiplier with two operand stream inputs and one result stream output. It retires `BITS_PER_CYCLE` multiplier bits per cycle and supports per-transaction signed/unsigned mode. It produces a fixed-point result with round-half-up, saturation and an overflow flag, and can capture the next operand pair while the current one is being computed. It sits in the datapath wherever a low-area multiply on valid/ready streams is needed.

---
 rtl/shift_add_multiplier_radix.sv | 230 +++++++++++++++++++++++
 tb/tb_shift_add_multiplier_radix.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier_radix.sv
// Sequential valid/ready multiplier retiring BITS_PER_CYCLE multiplier bits per cycle,
// with per-transaction signed/unsigned mode, round-half-up, saturation and overflow flag.
`timescale 1ns/1ps
module shift_add_multiplier_radix #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1,
  parameter int FRAC_BITS      = WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tvalid_slave_1,
  input  logic [WIDTH-1:0] tdata_slave_1,
  input  logic             tuser_slave_1,
  output logic             tready_slave_1,
  input  logic             tvalid_slave_2,
  input  logic [WIDTH-1:0] tdata_slave_2,
  output logic             tready_slave_2,
  output logic             tvalid_master,
  output logic [WIDTH-1:0] tdata_master,
  output logic             tuser_master,
  input  logic             tready_master
);

  // state   | meaning
  // COLLECT | waiting for both operands to be held
  // PREP    | load magnitudes and sign, clear accumulator
  // CALC    | accumulate one BITS_PER_CYCLE digit of B per cycle
  // FINAL   | negate, round, saturate, load result register
  // OUTPUT  | present result until downstream accepts it

  localparam int N       = WIDTH / BITS_PER_CYCLE;
  localparam int CW      = (N > 1) ? $clog2(N) : 1;
  localparam int AW      = 2 * WIDTH;
  localparam int PW      = 2 * WIDTH + 2;
  localparam int HALF_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

  localparam logic signed [PW-1:0] S_MAX = PW'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [PW-1:0] S_MIN = ~S_MAX;
  localparam logic signed [PW-1:0] U_MAX = PW'({WIDTH{1'b1}});

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_PREP    = 3'd1,
    ST_CALC    = 3'd2,
    ST_FINAL   = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic             held_a_q, held_a_d;
  logic             held_b_q, held_b_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;

  // Multiplicand is kept pre-shifted to the weight of the current digit of B.
  logic [AW-1:0]    a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic             neg_q, neg_d;
  logic             sgn_q, sgn_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    step_q, step_d;

  logic             tvalid_q, tvalid_d;
  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             tuser_q, tuser_d;

  logic             hs_a, hs_b;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [AW-1:0]    b_lo_ext, pp;
  logic signed [PW-1:0] p_s, r_s, round_add;
  logic [WIDTH-1:0] sat_data;
  logic             sat_ovf;

  assign tready_slave_1 = !held_a_q && !reset;
  assign tready_slave_2 = !held_b_q && !reset;
  assign hs_a           = tvalid_slave_1 && tready_slave_1;
  assign hs_b           = tvalid_slave_2 && tready_slave_2;

  assign a_abs    = (mode_q && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_abs    = (mode_q && b_q[WIDTH-1]) ? -b_q : b_q;
  assign b_lo_ext = AW'(b_mag_q[BITS_PER_CYCLE-1:0]);
  assign pp       = a_sh_q * b_lo_ext;

  assign tvalid_master = tvalid_q;
  assign tdata_master  = tdata_q;
  assign tuser_master  = tuser_q;

  // Rounding adds half an LSB then shifts arithmetically, so ties go toward +inf.
  always_comb begin
    p_s = $signed({2'b00, acc_q});
    if (neg_q) begin
      p_s = -p_s;
    end
    round_add = (FRAC_BITS > 0) ? (PW'(1) << HALF_SH) : '0;
    r_s       = (p_s + round_add) >>> FRAC_BITS;

    sat_ovf  = 1'b0;
    sat_data = r_s[WIDTH-1:0];
    if (sgn_q) begin
      if (r_s > S_MAX) begin
        sat_ovf  = 1'b1;
        sat_data = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (r_s < S_MIN) begin
        sat_ovf  = 1'b1;
        sat_data = {1'b1, {(WIDTH-1){1'b0}}};
      end
    end else begin
      if (r_s > U_MAX) begin
        sat_ovf  = 1'b1;
        sat_data = {WIDTH{1'b1}};
      end else if (r_s[PW-1]) begin
        sat_ovf  = 1'b1;
        sat_data = '0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    held_a_d = held_a_q;
    held_b_d = held_b_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    a_sh_d   = a_sh_q;
    b_mag_d  = b_mag_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    acc_d    = acc_q;
    step_d   = step_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;

    if (state_q == ST_PREP) begin
      held_a_d = 1'b0;
      held_b_d = 1'b0;
    end
    if (hs_a) begin
      held_a_d = 1'b1;
      a_d      = tdata_slave_1;
      mode_d   = tuser_slave_1;
    end
    if (hs_b) begin
      held_b_d = 1'b1;
      b_d      = tdata_slave_2;
    end

    case (state_q)
      ST_COLLECT: begin
        if ((held_a_q || hs_a) && (held_b_q || hs_b)) begin
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        a_sh_d  = AW'(a_abs);
        b_mag_d = b_abs;
        neg_d   = mode_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        sgn_d   = mode_q;
        acc_d   = '0;
        step_d  = '0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        acc_d   = acc_q + pp;
        a_sh_d  = a_sh_q << BITS_PER_CYCLE;
        b_mag_d = b_mag_q >> BITS_PER_CYCLE;
        step_d  = step_q + 1'b1;
        if (step_q == CW'(N - 1)) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        tdata_d  = sat_data;
        tuser_d  = sat_ovf;
        tvalid_d = 1'b1;
        state_d  = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        // Only pairs already held at this edge may skip COLLECT.
        if (tready_master) begin
          tvalid_d = 1'b0;
          state_d  = (held_a_q && held_b_q) ? ST_PREP : ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_COLLECT;
      held_a_q <= 1'b0;
      held_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      a_sh_q   <= '0;
      b_mag_q  <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      acc_q    <= '0;
      step_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_a_q <= held_a_d;
      held_b_q <= held_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      a_sh_q   <= a_sh_d;
      b_mag_q  <= b_mag_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier_radix.sv
// Directed and reference-model bench for shift_add_multiplier_radix; a BPC=1 and a BPC=4
// instance share stimulus, selected by sel.
`timescale 1ns/1ps
module tb_shift_add_multiplier_radix;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic [15:0] d;
    logic        u;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        tvalid_slave_1, tuser_slave_1, tvalid_slave_2, tready_master;
  logic [15:0] tdata_slave_1, tdata_slave_2;

  logic        r1_a, r2_a, v_a, u_a;
  logic        r1_b, r2_b, v_b, u_b;
  logic [15:0] d_a, d_b;

  logic        s_rdy1, s_rdy2, m_tvalid, m_tuser;
  logic [15:0] m_tdata;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_add_multiplier_radix #(.WIDTH(16), .BITS_PER_CYCLE(1), .FRAC_BITS(15)) dut1 (
    .clk(clk), .reset(reset),
    .tvalid_slave_1(tvalid_slave_1 && !sel), .tdata_slave_1(tdata_slave_1),
    .tuser_slave_1(tuser_slave_1), .tready_slave_1(r1_a),
    .tvalid_slave_2(tvalid_slave_2 && !sel), .tdata_slave_2(tdata_slave_2),
    .tready_slave_2(r2_a),
    .tvalid_master(v_a), .tdata_master(d_a), .tuser_master(u_a),
    .tready_master(tready_master && !sel)
  );

  shift_add_multiplier_radix #(.WIDTH(16), .BITS_PER_CYCLE(4), .FRAC_BITS(15)) dut4 (
    .clk(clk), .reset(reset),
    .tvalid_slave_1(tvalid_slave_1 && sel), .tdata_slave_1(tdata_slave_1),
    .tuser_slave_1(tuser_slave_1), .tready_slave_1(r1_b),
    .tvalid_slave_2(tvalid_slave_2 && sel), .tdata_slave_2(tdata_slave_2),
    .tready_slave_2(r2_b),
    .tvalid_master(v_b), .tdata_master(d_b), .tuser_master(u_b),
    .tready_master(tready_master && sel)
  );

  assign s_rdy1   = sel ? r1_b : r1_a;
  assign s_rdy2   = sel ? r2_b : r2_a;
  assign m_tvalid = sel ? v_b  : v_a;
  assign m_tdata  = sel ? d_b  : d_a;
  assign m_tuser  = sel ? u_b  : u_a;

  function automatic logic [16:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic m);
    longint p, r;
    if (m) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'({48'd0, a}) * longint'({48'd0, b});
    r = (p + 64'sd16384) >>> 15;
    if (m) begin
      if (r > 32767)       return {1'b1, 16'h7FFF};
      else if (r < -32768) return {1'b1, 16'h8000};
      else                 return {1'b0, r[15:0]};
    end else begin
      if (r > 65535)       return {1'b1, 16'hFFFF};
      else if (r < 0)      return {1'b1, 16'h0000};
      else                 return {1'b0, r[15:0]};
    end
  endfunction

  // Presents a pair; B is offered b_lead cycles before A. Returns cyc just after the
  // edge on which the last operand handshook.
  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic m,
                           input int b_lead, output int hs_cyc);
    bit da = 0, db = 0, ha, hb;
    int n = 0;
    tdata_slave_1  = a;
    tuser_slave_1  = m;
    tdata_slave_2  = b;
    tvalid_slave_2 = 1'b1;
    tvalid_slave_1 = (b_lead == 0);
    while (!(da && db) && n < 100) begin
      ha = tvalid_slave_1 && s_rdy1;
      hb = tvalid_slave_2 && s_rdy2;
      @(posedge clk); #1;
      n++;
      if (ha) begin da = 1; tvalid_slave_1 = 1'b0; end
      if (hb) begin db = 1; tvalid_slave_2 = 1'b0; end
      if (!da && n >= b_lead) tvalid_slave_1 = 1'b1;
    end
    tvalid_slave_1 = 1'b0;
    tvalid_slave_2 = 1'b0;
    hs_cyc = cyc;
    n_assert++;
    if (!(da && db)) begin
      n_fail++;
      $display("FAIL send_pair: handshake a=%0b b=%0b after %0d cycles, required both", da, db, n);
    end
  endtask

  task automatic get_result(input int hs_cyc, output logic [15:0] d, output logic u,
                            output int lat);
    int n = 0;
    while (!m_tvalid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    lat = cyc - hs_cyc + 1;
    d   = m_tdata;
    u   = m_tuser;
    n_assert++;
    if (!m_tvalid) begin
      n_fail++;
      $display("FAIL get_result: tvalid_master=0 after 60 cycles, required 1");
    end
  endtask

  task automatic pop();
    tready_master = 1'b1;
    @(posedge clk); #1;
    tready_master = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    reset = 1'b1;
    #1;
    n_assert++;
    if (s_rdy1 !== 1'b0 || s_rdy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_low: got %b%b required 00", s_rdy1, s_rdy2);
    end
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if ({v_a, d_a, u_a, v_b, d_b, u_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h u=%b / v=%b d=%h u=%b required all 0",
               v_a, d_a, u_a, v_b, d_b, u_b);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_assert++;
    if (r1_a !== 1'b1 || r2_a !== 1'b1 || r1_b !== 1'b1 || r2_b !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b%b%b%b required 1111", r1_a, r2_a, r1_b, r2_b);
    end
  endtask

  task automatic test_directed();
    vec_t tbl [9] = '{
      '{16'h4000, 16'h4000, 1'b1, 16'h2000, 1'b0},
      '{16'h4000, 16'hC000, 1'b1, 16'hE000, 1'b0},
      '{16'h8000, 16'h8000, 1'b1, 16'h7FFF, 1'b1},
      '{16'hFFFF, 16'h0002, 1'b0, 16'h0004, 1'b0},
      '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 1'b1},
      '{16'h8000, 16'h7FFF, 1'b1, 16'h8001, 1'b0},
      '{16'h0001, 16'h4000, 1'b1, 16'h0001, 1'b0},
      '{16'hFFFF, 16'h4000, 1'b1, 16'h0000, 1'b0},
      '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0}
    };
    int hs, lat;
    logic [15:0] d;
    logic u;
    sel = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send_pair(tbl[i].a, tbl[i].b, tbl[i].m, 0, hs);
      get_result(hs, d, u, lat);
      n_assert++;
      if (d !== tbl[i].d) begin
        n_fail++;
        $display("FAIL directed_data[%0d]: got %h required %h", i, d, tbl[i].d);
      end
      n_assert++;
      if (u !== tbl[i].u) begin
        n_fail++;
        $display("FAIL directed_ovf[%0d]: got %b required %b", i, u, tbl[i].u);
      end
      n_assert++;
      if (lat !== 19) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d required 19", i, lat);
      end
      pop();
      n_assert++;
      if (m_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_pop[%0d]: tvalid got %b required 0", i, m_tvalid);
      end
    end
  endtask

  task automatic test_arrival();
    int hs, lat;
    logic [15:0] d;
    logic u;
    sel = 1'b0;
    send_pair(16'h3000, 16'h2000, 1'b1, 5, hs);
    get_result(hs, d, u, lat);
    n_assert++;
    if ({u, d} !== {1'b0, 16'h0C00} || lat !== 19) begin
      n_fail++;
      $display("FAIL b_first: got u=%b d=%h lat=%0d required u=0 d=0c00 lat=19", u, d, lat);
    end
    pop();
    send_pair(16'hF000, 16'h1000, 1'b1, 0, hs);
    get_result(hs, d, u, lat);
    n_assert++;
    if ({u, d} !== {1'b0, 16'hFE00} || lat !== 19) begin
      n_fail++;
      $display("FAIL same_cycle: got u=%b d=%h lat=%0d required u=0 d=fe00 lat=19", u, d, lat);
    end
    pop();
  endtask

  task automatic test_overlap();
    int hs1, hs2, hs3, lat;
    logic [15:0] d;
    logic u;
    sel = 1'b0;
    send_pair(16'h4000, 16'h4000, 1'b1, 0, hs1);
    send_pair(16'h2000, 16'h6000, 1'b0, 0, hs2);
    n_assert++;
    if (hs2 - hs1 !== 2) begin
      n_fail++;
      $display("FAIL overlap_capture: second pair after %0d cycles, required 2", hs2 - hs1);
    end
    get_result(hs1, d, u, lat);
    n_assert++;
    if ({u, d} !== {1'b0, 16'h2000} || lat !== 19) begin
      n_fail++;
      $display("FAIL overlap_first: got u=%b d=%h lat=%0d required u=0 d=2000 lat=19", u, d, lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_assert++;
      if ({m_tvalid, m_tdata, m_tuser, s_rdy1, s_rdy2} !== {1'b1, 16'h2000, 1'b0, 2'b00}) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got v=%b d=%h u=%b rdy=%b%b required v=1 d=2000 u=0 rdy=00",
                 i, m_tvalid, m_tdata, m_tuser, s_rdy1, s_rdy2);
      end
    end
    pop();
    hs3 = cyc;
    n_assert++;
    if (m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL overlap_pop: tvalid got %b required 0", m_tvalid);
    end
    get_result(hs3, d, u, lat);
    n_assert++;
    if ({u, d} !== {1'b0, 16'h1800} || lat !== 19) begin
      n_fail++;
      $display("FAIL overlap_second: got u=%b d=%h lat=%0d required u=0 d=1800 lat=19", u, d, lat);
    end
    pop();
  endtask

  task automatic test_async_reset();
    int hs, lat, stale;
    logic [15:0] d;
    logic u;
    sel = 1'b0;
    send_pair(16'h1234, 16'h0100, 1'b0, 0, hs);
    repeat (5) @(posedge clk);
    #4;
    reset = 1'b1;
    #1;
    n_assert++;
    if ({v_a, d_a, u_a, r1_a, r2_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_calc: got v=%b d=%h u=%b rdy=%b%b required all 0",
               v_a, d_a, u_a, r1_a, r2_a);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (m_tvalid) stale++;
    end
    n_assert++;
    if (stale !== 0) begin
      n_fail++;
      $display("FAIL stale_after_calc_reset: tvalid high %0d cycles, required 0", stale);
    end
    send_pair(16'h7000, 16'h7000, 1'b1, 0, hs);
    get_result(hs, d, u, lat);
    n_assert++;
    if ({u, d} !== {1'b0, 16'h6200}) begin
      n_fail++;
      $display("FAIL pre_output_reset: got u=%b d=%h required u=0 d=6200", u, d);
    end
    #3;
    reset = 1'b1;
    #1;
    n_assert++;
    if ({v_a, d_a, u_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_output: got v=%b d=%h u=%b required all 0", v_a, d_a, u_a);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (m_tvalid) stale++;
    end
    n_assert++;
    if (stale !== 0) begin
      n_fail++;
      $display("FAIL stale_after_output_reset: tvalid high %0d cycles, required 0", stale);
    end
    send_pair(16'h1234, 16'h0100, 1'b0, 0, hs);
    get_result(hs, d, u, lat);
    n_assert++;
    if ({u, d} !== {1'b0, 16'h0024} || lat !== 19) begin
      n_fail++;
      $display("FAIL post_reset_pair: got u=%b d=%h lat=%0d required u=0 d=0024 lat=19", u, d, lat);
    end
    pop();
  endtask

  task automatic test_random();
    logic [15:0] ra [100];
    logic [15:0] rb [100];
    logic        rm [100];
    logic [16:0] exp_v;
    logic [15:0] d;
    logic u;
    int hs, lat, exp_lat;
    for (int i = 0; i < 100; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rm[i] = 1'($urandom_range(0, 1));
      if (i % 10 == 0) ra[i] = 16'h8000;
      if (i % 10 == 1) rb[i] = 16'hFFFF;
    end
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      exp_lat = (s == 1) ? 7 : 19;
      for (int i = 0; i < 100; i++) begin
        exp_v = ref_mul(ra[i], rb[i], rm[i]);
        send_pair(ra[i], rb[i], rm[i], 0, hs);
        get_result(hs, d, u, lat);
        n_assert++;
        if ({u, d} !== exp_v) begin
          n_fail++;
          $display("FAIL random_bpc%0d[%0d]: a=%h b=%h m=%b got u=%b d=%h required u=%b d=%h",
                   (s == 1) ? 4 : 1, i, ra[i], rb[i], rm[i], u, d, exp_v[16], exp_v[15:0]);
        end
        n_assert++;
        if (lat !== exp_lat) begin
          n_fail++;
          $display("FAIL random_latency_bpc%0d[%0d]: got %0d required %0d",
                   (s == 1) ? 4 : 1, i, lat, exp_lat);
        end
        pop();
      end
    end
  endtask

  initial begin
    sel            = 1'b0;
    reset          = 1'b0;
    tvalid_slave_1 = 1'b0;
    tvalid_slave_2 = 1'b0;
    tuser_slave_1  = 1'b0;
    tdata_slave_1  = '0;
    tdata_slave_2  = '0;
    tready_master  = 1'b0;
    test_reset();
    test_directed();
    test_arrival();
    test_overlap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
